// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM and MEM/WB registers around a request/ready data-memory handshake.
// Zero-wait accesses add no latency. A pending access holds the front end via mem_stall until ready or timeout.
module mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic        EX_MemtoReg,
    input  logic [4:0]  EX_RegWriteA,
    input  logic [31:0] EX_ALUResult,
    input  logic [31:0] EX_WriteData,
    input  logic [3:0]  EX_LoadType,
    input  logic [2:0]  EX_SaveType,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        mem_stall,
    output logic [31:0] EX_MEM_ALUResult,
    output logic [4:0]  EX_MEM_RegWriteA,
    output logic        EX_MEM_RegWrite,
    output logic        MEM_WB_RegWrite,
    output logic [4:0]  MEM_WB_RegWriteA,
    output logic [31:0] WB_Data,
    output logic        mem_err
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    logic        exMemMemRead;
    logic        exMemMemWrite;
    logic        exMemMemtoReg;
    logic [31:0] exMemWriteData;
    logic [3:0]  exMemLoadType;
    logic [2:0]  exMemSaveType;

    logic        memWbMemtoReg;
    logic [31:0] memWbALUResult;
    logic [31:0] memWbReadData;

    state_t      state;
    state_t      nextState;
    logic [7:0]  waitCnt;
    logic [7:0]  nextCnt;

    logic        isByte;
    logic        isHalf;
    logic        access;
    logic        misaligned;
    logic        alignedAccess;
    logic        abort;
    logic        complete;
    logic        wbCapture;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;

    // Stores decode their size from SaveType, everything else from LoadType.
    always_comb begin
        isByte = 1'b0;
        isHalf = 1'b0;
        if (exMemMemWrite) begin
            isByte = (exMemSaveType == 3'd1);
            isHalf = (exMemSaveType == 3'd2);
        end else begin
            isByte = (exMemLoadType == 4'd1) || (exMemLoadType == 4'd2);
            isHalf = (exMemLoadType == 4'd3) || (exMemLoadType == 4'd4);
        end
    end

    assign access        = exMemMemRead | exMemMemWrite;
    assign misaligned    = access & ((isHalf & EX_MEM_ALUResult[0]) |
                                     (~isByte & ~isHalf & (EX_MEM_ALUResult[1:0] != 2'b00)));
    assign alignedAccess = access & ~misaligned;
    assign abort         = alignedAccess & (state == ST_WAIT) & (waitCnt == LAST_WAIT) & ~dmem_ready;
    assign complete      = alignedAccess & dmem_ready;
    assign wbCapture     = ~access | complete;

    assign mem_stall = alignedAccess & ~dmem_ready & ~abort;
    assign dmem_req  = alignedAccess;
    assign dmem_we   = exMemMemWrite;
    assign dmem_addr = {EX_MEM_ALUResult[31:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = exMemWriteData;
        if (exMemMemWrite) begin
            if (isByte) begin
                dmem_be    = 4'b0001 << EX_MEM_ALUResult[1:0];
                dmem_wdata = {4{exMemWriteData[7:0]}};
            end else if (isHalf) begin
                dmem_be    = EX_MEM_ALUResult[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{exMemWriteData[15:0]}};
            end
        end
    end

    always_comb begin
        loadByte = dmem_rdata[7:0];
        case (EX_MEM_ALUResult[1:0])
            2'd1:    loadByte = dmem_rdata[15:8];
            2'd2:    loadByte = dmem_rdata[23:16];
            2'd3:    loadByte = dmem_rdata[31:24];
            default: loadByte = dmem_rdata[7:0];
        endcase
        loadHalf = EX_MEM_ALUResult[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (exMemLoadType)
            4'd1:    loadData = {{24{loadByte[7]}}, loadByte};
            4'd2:    loadData = {24'd0, loadByte};
            4'd3:    loadData = {{16{loadHalf[15]}}, loadHalf};
            4'd4:    loadData = {16'd0, loadHalf};
            default: loadData = dmem_rdata;
        endcase
    end

    always_comb begin
        nextState = state;
        nextCnt   = waitCnt;
        case (state)
            ST_IDLE: begin
                if (alignedAccess && !dmem_ready) begin
                    nextState = ST_WAIT;
                    nextCnt   = 8'd0;
                end
            end
            ST_WAIT: begin
                nextCnt = waitCnt + 8'd1;
                if (!alignedAccess || dmem_ready || abort) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            waitCnt <= 8'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextCnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_MEM_RegWrite  <= 1'b0;
            exMemMemRead     <= 1'b0;
            exMemMemWrite    <= 1'b0;
            exMemMemtoReg    <= 1'b0;
            EX_MEM_RegWriteA <= 5'd0;
            EX_MEM_ALUResult <= 32'd0;
            exMemWriteData   <= 32'd0;
            exMemLoadType    <= 4'd0;
            exMemSaveType    <= 3'd0;
        end else if (!mem_stall) begin
            EX_MEM_RegWrite  <= EX_RegWrite;
            exMemMemRead     <= EX_MemRead;
            exMemMemWrite    <= EX_MemWrite;
            exMemMemtoReg    <= EX_MemtoReg;
            EX_MEM_RegWriteA <= EX_RegWriteA;
            EX_MEM_ALUResult <= EX_ALUResult;
            exMemWriteData   <= EX_WriteData;
            exMemLoadType    <= EX_LoadType;
            exMemSaveType    <= EX_SaveType;
        end
    end

    // Stalls, misaligned accesses and timeouts all hand WB a fully cleared bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MEM_WB_RegWrite  <= 1'b0;
            memWbMemtoReg    <= 1'b0;
            MEM_WB_RegWriteA <= 5'd0;
            memWbALUResult   <= 32'd0;
            memWbReadData    <= 32'd0;
            mem_err          <= 1'b0;
        end else begin
            mem_err <= misaligned | abort;
            if (wbCapture) begin
                MEM_WB_RegWrite  <= EX_MEM_RegWrite;
                memWbMemtoReg    <= exMemMemtoReg;
                MEM_WB_RegWriteA <= EX_MEM_RegWriteA;
                memWbALUResult   <= EX_MEM_ALUResult;
                memWbReadData    <= loadData;
            end else begin
                MEM_WB_RegWrite  <= 1'b0;
                memWbMemtoReg    <= 1'b0;
                MEM_WB_RegWriteA <= 5'd0;
                memWbALUResult   <= 32'd0;
                memWbReadData    <= 32'd0;
            end
        end
    end

    assign WB_Data = memWbMemtoReg ? memWbReadData : memWbALUResult;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed test-plan sequence, then random instructions against a transaction-level model.
module tb_mem_stage;
    localparam int MW = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg;
    logic [4:0]  EX_RegWriteA;
    logic [31:0] EX_ALUResult, EX_WriteData;
    logic [3:0]  EX_LoadType;
    logic [2:0]  EX_SaveType;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic        mem_stall;
    logic [31:0] EX_MEM_ALUResult;
    logic [4:0]  EX_MEM_RegWriteA;
    logic        EX_MEM_RegWrite;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_RegWriteA;
    logic [31:0] WB_Data;
    logic        mem_err;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemtoReg(EX_MemtoReg), .EX_RegWriteA(EX_RegWriteA), .EX_ALUResult(EX_ALUResult),
        .EX_WriteData(EX_WriteData), .EX_LoadType(EX_LoadType), .EX_SaveType(EX_SaveType),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .mem_stall(mem_stall), .EX_MEM_ALUResult(EX_MEM_ALUResult),
        .EX_MEM_RegWriteA(EX_MEM_RegWriteA), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_RegWriteA(MEM_WB_RegWriteA),
        .WB_Data(WB_Data), .mem_err(mem_err)
    );

    typedef struct {
        logic        rw, mr, mw, m2r;
        logic [4:0]  rd;
        logic [31:0] alu, wd, rdata;
        logic [3:0]  lt;
        logic [2:0]  st;
        int          waitCyc;   // cycles the memory keeps ready low; > MW means never
    } instr_t;

    int assertions = 0;
    int failures   = 0;
    instr_t dirQ[$];
    instr_t pres, m;
    int     waitIdx;
    bit     advanced;
    logic   expWbRw, expErr;
    logic [4:0]  expWbA;
    logic [31:0] expWbData;
    int     stallCnt = 0;
    int     errCnt = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int accSize(logic mw, logic [3:0] lt, logic [2:0] st);
        if (mw) return (st == 3'd1) ? 1 : (st == 3'd2) ? 2 : 4;
        return (lt == 4'd1 || lt == 4'd2) ? 1 : (lt == 4'd3 || lt == 4'd4) ? 2 : 4;
    endfunction

    function automatic logic [3:0] modelBe(logic mw, logic [2:0] st, logic [31:0] a);
        int off = int'(a % 4);
        if (!mw) return 4'hF;
        case (accSize(1'b1, 4'd0, st))
            1:       return 4'(1 << off);
            2:       return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] modelWdata(logic [2:0] st, logic [31:0] d);
        case (accSize(1'b1, 4'd0, st))
            1:       return (d & 32'hFF) * 32'h01010101;
            2:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(logic [3:0] lt, logic [31:0] a, logic [31:0] r);
        int off = int'(a % 4);
        int v;
        case (lt)
            4'd1, 4'd2: begin
                v = int'((r >> (8 * off)) & 32'hFF);
                if (lt == 4'd1 && v >= 128) v -= 256;
            end
            4'd3, 4'd4: begin
                v = int'((r >> (8 * off)) & 32'hFFFF);
                if (lt == 4'd3 && v >= 32768) v -= 65536;
            end
            default: return r;
        endcase
        return 32'(v);
    endfunction

    function automatic instr_t mk(logic rw, logic mr, logic mw, logic m2r, logic [4:0] rd,
                                  logic [31:0] alu, logic [31:0] wd, logic [3:0] lt,
                                  logic [2:0] st, int w, logic [31:0] rdata);
        instr_t i;
        i.rw = rw; i.mr = mr; i.mw = mw; i.m2r = m2r; i.rd = rd;
        i.alu = alu; i.wd = wd; i.lt = lt; i.st = st; i.waitCyc = w; i.rdata = rdata;
        return i;
    endfunction

    function automatic instr_t randInstr();
        instr_t i;
        int kind = $urandom_range(0, 2);
        int r = $urandom_range(0, 9);
        i = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'($urandom), 32'h100 + $urandom_range(0, 63), $urandom,
               4'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), 0, $urandom);
        if (kind == 1) begin
            i.mr = 1'b1; i.rw = 1'b1; i.m2r = 1'b1;
        end else if (kind == 2) begin
            i.mw = 1'b1;
        end else begin
            i.rw = 1'($urandom_range(0, 1)); i.alu = $urandom;
        end
        i.waitCyc = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 4) : (r == 8) ? MW : 99;
        return i;
    endfunction

    function automatic instr_t nextInstr();
        if (dirQ.size() > 0) return dirQ.pop_front();
        return randInstr();
    endfunction

    task automatic drive(instr_t i);
        EX_RegWrite = i.rw; EX_MemRead = i.mr; EX_MemWrite = i.mw; EX_MemtoReg = i.m2r;
        EX_RegWriteA = i.rd; EX_ALUResult = i.alu; EX_WriteData = i.wd;
        EX_LoadType = i.lt; EX_SaveType = i.st;
    endtask

    // One clock of the model: m is the instruction in MEM, waitIdx the cycles it has waited so far.
    task automatic runCycle();
        int   size;
        logic acc, mis, req, rdy, abortE, stallE;
        @(negedge clk);
        check("wb_regwrite", MEM_WB_RegWrite, expWbRw);
        if (expWbRw) begin
            check("wb_rega", MEM_WB_RegWriteA, expWbA);
            check("wb_data", WB_Data, expWbData);
        end
        check("mem_err", mem_err, expErr);
        if (mem_err) errCnt++;
        check("exmem_alu", EX_MEM_ALUResult, m.alu);
        check("exmem_rw", EX_MEM_RegWrite, m.rw);
        check("exmem_rega", EX_MEM_RegWriteA, m.rd);
        if (advanced) begin
            pres = nextInstr();
            drive(pres);
        end
        acc  = m.mr | m.mw;
        size = accSize(m.mw, m.lt, m.st);
        mis  = acc && (m.alu % size != 0);
        req  = acc && !mis;
        if (req) begin
            rdy = (waitIdx == m.waitCyc);
            dmem_rdata = rdy ? m.rdata : $urandom;
        end else begin
            rdy = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
        end
        dmem_ready = rdy;
        #1;
        check("dmem_req", dmem_req, req);
        if (req) begin
            check("dmem_we", dmem_we, m.mw);
            check("dmem_addr", dmem_addr, m.alu - (m.alu % 4));
            check("dmem_be", dmem_be, modelBe(m.mw, m.st, m.alu));
            if (m.mw) check("dmem_wdata", dmem_wdata, modelWdata(m.st, m.wd));
        end
        abortE = req && !rdy && (waitIdx == MW);
        stallE = req && !rdy && (waitIdx < MW);
        check("mem_stall", mem_stall, stallE);
        if (mem_stall) stallCnt++;
        if (stallE) begin
            expWbRw = 1'b0; expErr = 1'b0;
            waitIdx++;
            advanced = 1'b0;
        end else begin
            if (!acc || (req && rdy)) begin
                expWbRw   = m.rw;
                expWbA    = m.rd;
                expWbData = m.m2r ? modelLoad(m.lt, m.alu, dmem_rdata) : m.alu;
            end else begin
                expWbRw = 1'b0;
            end
            expErr   = mis || abortE;
            m        = pres;
            waitIdx  = 0;
            advanced = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        m = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 3'd0, 0, 32'd0);
        pres = m;
        drive(m);
        dmem_ready = 1'b0; dmem_rdata = 32'd0;
        waitIdx = 0; advanced = 1'b1;
        expWbRw = 1'b0; expErr = 1'b0; expWbA = 5'd0; expWbData = 32'd0;

        // Hand-computed values that pin the model.
        check("pin_sb_be", modelBe(1'b1, 3'd1, 32'h103), 4'b1000);
        check("pin_sb_wdata", modelWdata(3'd1, 32'hAB), 32'hABABABAB);
        check("pin_sh_be", modelBe(1'b1, 3'd2, 32'h102), 4'b1100);
        check("pin_lb", modelLoad(4'd1, 32'h102, 32'h0080FF00), 32'hFFFFFF80);
        check("pin_lbu", modelLoad(4'd2, 32'h102, 32'h0080FF00), 32'h00000080);
        check("pin_lh", modelLoad(4'd3, 32'h102, 32'h80010000), 32'hFFFF8001);

        #12;
        check("rst_req", dmem_req, 1'b0);
        check("rst_stall", mem_stall, 1'b0);
        check("rst_wbdata", WB_Data, 32'd0);
        check("rst_err", mem_err, 1'b0);
        check("rst_wbrw", MEM_WB_RegWrite, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        dirQ.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h100, 32'h11223344, 4'd0, 3'd0, 0, 32'd0));
        dirQ.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h103, 32'h000000AB, 4'd0, 3'd1, 0, 32'd0));
        dirQ.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd5,  32'h102, 32'd0, 4'd1, 3'd0, 0, 32'h0080FF00));
        dirQ.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd6,  32'h102, 32'd0, 4'd2, 3'd0, 0, 32'h0080FF00));
        dirQ.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  32'h102, 32'd0, 4'd3, 3'd0, 3, 32'h80010000));
        dirQ.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  32'h1234, 32'd0, 4'd0, 3'd0, 0, 32'd0));
        dirQ.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  32'h101, 32'd0, 4'd0, 3'd0, 0, 32'd0));
        dirQ.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h101, 32'd0, 4'd3, 3'd0, 0, 32'd0));
        dirQ.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 32'h200, 32'd0, 4'd0, 3'd0, 99, 32'd0));
        for (int k = 0; k < 3; k++)
            dirQ.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 3'd0, 0, 32'd0));
        for (int k = 0; k < 200 && dirQ.size() > 0; k++) runCycle();
        check("directed_drained", 32'(dirQ.size()), 32'd0);
        check("directed_stall_cycles", 32'(stallCnt), 32'd18);
        check("directed_err_pulses", 32'(errCnt), 32'd3);

        for (int n = 0; n < 3000; n++) runCycle();

        dirQ.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'hDEAD0000, 32'd0, 4'd0, 3'd0, 99, 32'd0));
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            runCycle();
            found = (m.alu == 32'hDEAD0000) && (waitIdx == 5);
        end
        check("reach_wait", found, 1'b1);
        #2;
        check("wait_req", dmem_req, found);
        rst_n = 1'b0;
        #1;
        check("arst_req", dmem_req, 1'b0);
        check("arst_stall", mem_stall, 1'b0);
        check("arst_wbdata", WB_Data, 32'd0);
        check("arst_err", mem_err, 1'b0);
        check("arst_wbrw", MEM_WB_RegWrite, 1'b0);
        check("arst_exmem_alu", EX_MEM_ALUResult, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. Holds the EX/MEM pipeline register and runs the data-memory request/ready handshake, with byte-lane steering for stores and sign/zero extraction for loads. Holds the MEM/WB pipeline register and produces the write-back value that the execute stage uses for forwarding. Stalls the front of the pipeline while a memory access is outstanding.

## Interface
- MAX_WAIT, 15: wait cycles allowed for dmem_ready before the access is aborted (1..255).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg  in  1 each  control bits from the execute stage.
- EX_RegWriteA  in  5  destination register.
- EX_ALUResult  in  32  effective address or ALU result.
- EX_WriteData  in  32  store data, already forwarded.
- EX_LoadType  in  4  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; other values are treated as LW.
- EX_SaveType  in  3  0 SW, 1 SB, 2 SH; other values are treated as SW.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address, {addr[31:2], 2'b00}.
- dmem_be  out  4  byte enables, bit i selects data[8i+7:8i].
- dmem_wdata  out  32  store data, replicated across the lanes.
- dmem_rdata  in  32  read data, valid when dmem_ready is high.
- dmem_ready  in  1  completes the current request.
- mem_stall  out  1  hold the PC, IF/ID and ID/EX registers.
- EX_MEM_ALUResult  out  32  forwarding source.
- EX_MEM_RegWriteA  out  5  destination register in MEM, for forwarding.
- EX_MEM_RegWrite  out  1  write enable in MEM, for forwarding.
- MEM_WB_RegWrite  out  1  write enable in WB.
- MEM_WB_RegWriteA  out  5  destination register in WB.
- WB_Data  out  32  MEM_WB_MemtoReg ? MEM_WB_ReadData : MEM_WB_ALUResult.
- mem_err  out  1  one-cycle pulse on a misaligned access or a timeout.

## Operation
- **EX/MEM register**
  - Loads all EX_* inputs on every edge where mem_stall = 0.
  - Holds its value while mem_stall = 1.
- **Access and alignment**
  - access = EX_MEM_MemRead | EX_MEM_MemWrite.
  - Misaligned means either of:
    - halfword access with addr[0] = 1;
    - word access with addr[1:0] ≠ 0.
  - A misaligned access issues no request, pulses mem_err, and sends a bubble to WB (RegWrite = 0).
- **Store steering**
  - SB: be = 1 << addr[1:0], wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111, wdata = data.
  - Loads drive be = 4'b1111.
- **Load extraction**
  - The byte or halfword is selected from dmem_rdata by addr[1:0].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- **FSM states**
  - IDLE: dmem_req = aligned access.
    - dmem_ready = 1 completes the access in the same cycle.
    - Otherwise go to WAIT and clear the counter.
  - WAIT: dmem_req is held and all dmem_* outputs stay stable.
    - The counter increments every cycle.
    - dmem_ready = 1 completes the access and returns to IDLE.
    - counter = MAX_WAIT-1 with no ready: abort. Pulse mem_err, send a bubble to WB, return to IDLE.
- **mem_stall**
  - mem_stall = aligned access & !dmem_ready & !abort.
  - It is combinational and is asserted in IDLE and WAIT alike.
- **MEM/WB register**
  - Completed access, or a non-memory instruction: captures RegWrite, MemtoReg, RegWriteA, ALUResult and the extracted load data.
  - While stalled: loads a bubble (RegWrite = 0).
- **Reset**
  - FSM goes to IDLE, counter = 0.
  - Every register in both pipeline registers = 0, so dmem_req = 0, mem_stall = 0, WB_Data = 0, mem_err = 0.
  - Reset during WAIT drops dmem_req immediately; the memory must discard the request.

## Timing
- An instruction is captured into EX/MEM at edge N.
- Its result reaches MEM/WB at edge N+1+w, where w = number of cycles dmem_ready was low.
- With a zero-wait memory the stage adds no stall cycles.
- dmem_* outputs and mem_stall are combinational from the EX/MEM register, the FSM and dmem_ready.
- dmem_ready is only sampled while dmem_req = 1.
- dmem_ready asserted on the abort cycle: completion wins and no mem_err is raised.
- mem_err is registered: it is high for the cycle after the fault.

## Test plan
- SW of 0x11223344 to 0x100, zero wait -> one req cycle with be = 1111, wdata = 0x11223344; mem_stall never asserted.
- SB of 0xAB to 0x103 -> be = 1000, wdata = 0xABABABAB.
- LB from 0x102 with rdata = 0x0080FF00 -> WB_Data = 0xFFFFFF80. LBU from the same address -> 0x00000080.
- LH from 0x102 with rdata = 0x8001_0000 and dmem_ready delayed 3 cycles -> mem_stall high for 3 cycles, req stable, WB_Data = 0xFFFF8001. The following ADD reaches WB exactly 3 cycles late.
- LW from 0x101 -> no req, mem_err pulses once, MEM_WB_RegWrite = 0. Same for LH from 0x101.
- Ready withheld with MAX_WAIT = 15 -> abort after 15 cycles with a single mem_err pulse. Separately, assert rst_n low mid-WAIT -> all outputs 0 asynchronously.
